// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Brief    : Recovers pixel coordinates from a sampled VGA stream. Tracks
//            hsync/vsync edges, measures line period and sync width, and
//            runs a SEARCH/ACQUIRE/LOCKED lock machine. Colour bits are
//            registered alongside x/y and blanked outside the active area.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
  parameter int H_TOTAL      = 1056,
  parameter int H_ACTIVE     = 800,
  parameter int H_SYNC_START = 840,
  parameter int H_SYNC_W     = 128,
  parameter int V_TOTAL      = 628,
  parameter int V_ACTIVE     = 600,
  parameter int V_SYNC_START = 601
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        red_i,
  input  logic        green_i,
  input  logic        blue_i,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        active,
  output logic        red_o,
  output logic        green_o,
  output logic        blue_o,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err,
  output logic [10:0] line_len
);

  // Timing constants in the 11-bit coordinate domain.
  localparam logic [10:0] c_h_total      = 11'(H_TOTAL);
  localparam logic [10:0] c_h_active     = 11'(H_ACTIVE);
  localparam logic [10:0] c_h_sync_start = 11'(H_SYNC_START);
  localparam logic [10:0] c_h_sync_w     = 11'(H_SYNC_W);
  localparam logic [10:0] c_v_total      = 11'(V_TOTAL);
  localparam logic [10:0] c_v_active     = 11'(V_ACTIVE);
  localparam logic [10:0] c_v_sync_start = 11'(V_SYNC_START);
  localparam logic [10:0] c_sat          = 11'h7FF;

  // Lock state encoding.
  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  // Previous sync samples; reset high so release never looks like a fall.
  logic        r_hs_q;
  logic        r_vs_q;

  logic [10:0] r_period;
  logic [10:0] r_width;
  logic [10:0] r_line_cnt;
  logic        r_seen_hfall;
  logic        r_err_flag;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;

  logic        w_hs_fall;
  logic        w_hs_rise;
  logic        w_vs_fall;
  logic        w_period_bad;
  logic        w_width_bad;
  logic        w_line_fail;
  logic        w_serr_set;
  logic        w_flag_clr;
  logic        w_flag_set;

  logic [10:0] w_x_next;
  logic [10:0] w_y_next;
  logic        w_x_wrap;
  logic        w_active_next;

  // Edge strobes: the incoming sample compared with the held previous sample.
  assign w_hs_fall = pix_en & r_hs_q & ~hsync;
  assign w_hs_rise = pix_en & ~r_hs_q & hsync;
  assign w_vs_fall = pix_en & r_vs_q & ~vsync;

  // Line checks stay quiet until a first hsync fall gives a reference point.
  assign w_period_bad = w_hs_fall & r_seen_hfall & (r_period != c_h_total);
  assign w_width_bad  = w_hs_rise & r_seen_hfall & (r_width != c_h_sync_w);
  assign w_line_fail  = w_period_bad | w_width_bad;

  // Sync sample stage, advanced only on pixel strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_q <= 1'b1;
      r_vs_q <= 1'b1;
    end else if (pix_en) begin
      r_hs_q <= hsync;
      r_vs_q <= vsync;
    end
  end

  // Period and hsync-low width counters, both saturating.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_period     <= '0;
      r_width      <= '0;
      r_seen_hfall <= 1'b0;
    end else if (pix_en) begin
      if (w_hs_fall) begin
        r_period <= 11'd1;
      end else if (r_period != c_sat) begin
        r_period <= r_period + 11'd1;
      end
      if (!hsync) begin
        if (w_hs_fall) begin
          r_width <= 11'd1;
        end else if (r_width != c_sat) begin
          r_width <= r_width + 11'd1;
        end
      end
      if (w_hs_fall) begin
        r_seen_hfall <= 1'b1;
      end
    end
  end

  // Lines between vsync falls, plus the acquisition error flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_line_cnt <= '0;
      r_err_flag <= 1'b0;
    end else begin
      if (w_vs_fall) begin
        r_line_cnt <= w_hs_fall ? 11'd1 : 11'd0;
      end else if (w_hs_fall && (r_line_cnt != c_sat)) begin
        r_line_cnt <= r_line_cnt + 11'd1;
      end
      if (w_flag_clr) begin
        r_err_flag <= w_flag_set;
      end else if (w_flag_set) begin
        r_err_flag <= 1'b1;
      end
    end
  end

  // Lock FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SEARCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Lock FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SEARCH: begin
        if (w_vs_fall) begin
          w_next_state = ACQUIRE;
        end
      end
      ACQUIRE: begin
        // A miss simply restarts acquisition in place.
        if (w_vs_fall && (r_line_cnt == c_v_total) && !r_err_flag && !w_line_fail) begin
          w_next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (w_line_fail || (w_vs_fall && (r_line_cnt != c_v_total))) begin
          w_next_state = SEARCH;
        end
      end
      default: begin
        w_next_state = SEARCH;
      end
    endcase
  end

  // Lock FSM outputs and counter/flag controls.
  always_comb begin
    locked     = (r_state == LOCKED);
    w_serr_set = 1'b0;
    w_flag_clr = 1'b0;
    w_flag_set = 1'b0;
    case (r_state)
      SEARCH: begin
        w_flag_clr = w_vs_fall;
      end
      ACQUIRE: begin
        w_flag_clr = w_vs_fall;
        w_flag_set = w_line_fail;
      end
      LOCKED: begin
        w_serr_set = w_line_fail | (w_vs_fall & (r_line_cnt != c_v_total));
      end
      default: begin
        w_serr_set = 1'b0;
      end
    endcase
  end

  // Next coordinates: sync falls reload, otherwise free-run with wrap.
  always_comb begin
    w_x_wrap = 1'b0;
    if (w_hs_fall) begin
      w_x_next = c_h_sync_start;
    end else if (x == (c_h_total - 11'd1)) begin
      w_x_next = '0;
      w_x_wrap = 1'b1;
    end else begin
      w_x_next = x + 11'd1;
    end

    if (w_vs_fall) begin
      w_y_next = c_v_sync_start;
    end else if (w_x_wrap) begin
      w_y_next = (y == (c_v_total - 11'd1)) ? 11'd0 : (y + 11'd1);
    end else begin
      w_y_next = y;
    end

    w_active_next = locked & (w_x_next < c_h_active) & (w_y_next < c_v_active);
  end

  // Registered coordinate/colour outputs and one-clock status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      red_o       <= 1'b0;
      green_o     <= 1'b0;
      blue_o      <= 1'b0;
      line_len    <= '0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_start <= pix_en & locked & (w_x_next == 11'd0) & (w_y_next == 11'd0);
      sync_err    <= w_serr_set;
      if (pix_en) begin
        x       <= w_x_next;
        y       <= w_y_next;
        active  <= w_active_next;
        red_o   <= red_i & w_active_next;
        green_o <= green_i & w_active_next;
        blue_o  <= blue_i & w_active_next;
        if (w_hs_fall) begin
          line_len <= r_period;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_decoder
// Brief    : Directed bench for vga_sync_decoder on a reduced raster
//            (40x20 total, 24x12 active) with a 1-in-3 pixel strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

  localparam int HT  = 40;
  localparam int HA  = 24;
  localparam int HSS = 28;
  localparam int HSW = 6;
  localparam int VT  = 20;
  localparam int VA  = 12;
  localparam int VSS = 13;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_en  = 1'b0;
  logic        hsync   = 1'b1;
  logic        vsync   = 1'b1;
  logic        red_i   = 1'b0;
  logic        green_i = 1'b0;
  logic        blue_i  = 1'b0;
  logic [10:0] x;
  logic [10:0] y;
  logic [10:0] line_len;
  logic        active;
  logic        red_o;
  logic        green_o;
  logic        blue_o;
  logic        locked;
  logic        frame_start;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  // Generator position and per-line shape.
  int gx = 0;
  int gy = 0;
  int gf = 0;
  int cur_ht  = HT;
  int cur_hsw = HSW;

  bit chk_xy     = 1'b0;
  bit exp_locked = 1'b0;
  bit exp_serr   = 1'b0;
  int act_cnt    = 0;
  int fs_cnt     = 0;
  logic pulses;

  vga_sync_decoder #(
    .H_TOTAL     (HT),
    .H_ACTIVE    (HA),
    .H_SYNC_START(HSS),
    .H_SYNC_W    (HSW),
    .V_TOTAL     (VT),
    .V_ACTIVE    (VA),
    .V_SYNC_START(VSS)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .red_i      (red_i),
    .green_i    (green_i),
    .blue_i     (blue_i),
    .x          (x),
    .y          (y),
    .active     (active),
    .red_o      (red_o),
    .green_o    (green_o),
    .blue_o     (blue_o),
    .locked     (locked),
    .frame_start(frame_start),
    .sync_err   (sync_err),
    .line_len   (line_len)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at f%0d y%0d x%0d", tag, obs, expv, gf, gy, gx);
    end
  endtask

  // One pixel sample: strobe, check the registered result, two idle clocks.
  task automatic step();
    logic ea;
    hsync   = !((gx >= HSS) && (gx < HSS + cur_hsw));
    vsync   = !((gy >= VSS) && (gy < VSS + 2));
    red_i   = 1'b1;
    green_i = gx[0];
    blue_i  = gy[0];
    pix_en  = 1'b1;
    @(posedge clock); #1;
    ea = exp_locked && (gx < HA) && (gy < VA);
    if (chk_xy) begin
      chk("x", 32'(x), gx);
      chk("y", 32'(y), gy);
    end
    if (chk_xy || !exp_locked) begin
      chk("active", 32'(active), 32'(ea));
      chk("red_o", 32'(red_o), 32'(ea));
      chk("green_o", 32'(green_o), 32'(ea & gx[0]));
      chk("blue_o", 32'(blue_o), 32'(ea & gy[0]));
      chk("frame_start", 32'(frame_start), 32'(exp_locked && (gx == 0) && (gy == 0)));
    end
    chk("sync_err", 32'(sync_err), 32'(exp_serr));
    act_cnt += 32'(active);
    fs_cnt  += 32'(frame_start);
    pix_en = 1'b0;
    @(posedge clock); #1;
    chk("frame_start_drop", 32'(frame_start), 32'd0);
    chk("sync_err_drop", 32'(sync_err), 32'd0);
    @(posedge clock); #1;
    gx++;
    if (gx >= cur_ht) begin
      gx      = 0;
      cur_ht  = HT;
      cur_hsw = HSW;
      gy++;
      if (gy == VT) begin
        gy = 0;
        gf++;
      end
    end
  endtask

  // Advance the stream until the next sample to emit is (f, yy, xx).
  task automatic run_to(input int f, input int yy, input int xx);
    int guard;
    guard = 0;
    while (!((gf == f) && (gy == yy) && (gx == xx)) && (guard < 20000)) begin
      step();
      guard++;
    end
    chk("run_to_reached", 32'((gf == f) && (gy == yy) && (gx == xx)), 32'd1);
  endtask

  initial begin
    // Power-on reset state.
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_line_len", 32'(line_len), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_red_o", 32'(red_o), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
    reset_n = 1'b1;

    // Acquisition: first vsync fall enters ACQUIRE, second one locks.
    run_to(0, VSS, 0);
    step();
    chk("acq_not_locked", 32'(locked), 32'd0);
    run_to(1, 0, 0);
    chk_xy = 1'b1;
    run_to(1, VSS, 0);
    chk("locked_before_2nd_vs", 32'(locked), 32'd0);
    step();
    chk("locked_at_2nd_vs", 32'(locked), 32'd1);
    exp_locked = 1'b1;

    // Nominal frame statistics.
    run_to(2, 0, 0);
    chk("line_len_nominal", 32'(line_len), HT);
    act_cnt = 0;
    fs_cnt  = 0;
    run_to(3, 0, 0);
    chk("active_per_frame", act_cnt, HA * VA);
    chk("frame_start_per_frame", fs_cnt, 32'd1);

    // Stretched line: one line of HT+1 samples.
    run_to(3, 3, 0);
    chk_xy = 1'b0;
    cur_ht = HT + 1;
    run_to(3, 4, HSS);
    exp_serr = 1'b1;
    step();
    exp_serr   = 1'b0;
    exp_locked = 1'b0;
    chk("long_line_unlock", 32'(locked), 32'd0);
    chk("long_line_len", 32'(line_len), HT + 1);
    run_to(3, 5, 0);
    chk_xy = 1'b1;
    run_to(3, VSS, 0);
    step();
    run_to(4, VSS, 0);
    chk("relock_pending", 32'(locked), 32'd0);
    step();
    chk("relock_after_long", 32'(locked), 32'd1);
    exp_locked = 1'b1;

    // Narrow hsync pulse.
    run_to(5, 2, 0);
    cur_hsw = HSW - 1;
    run_to(5, 2, HSS + HSW - 1);
    exp_serr = 1'b1;
    step();
    exp_serr   = 1'b0;
    exp_locked = 1'b0;
    chk("narrow_unlock", 32'(locked), 32'd0);
    run_to(5, VSS, 0);
    step();
    run_to(6, VSS, 0);
    step();
    chk("relock_after_narrow", 32'(locked), 32'd1);
    exp_locked = 1'b1;
    chk("line_len_restored", 32'(line_len), HT);

    // Strobe stall mid-line.
    run_to(7, 5, 10);
    step();
    pulses = 1'b0;
    repeat (100) begin
      @(posedge clock); #1;
      pulses = pulses | frame_start | sync_err;
    end
    chk("stall_x", 32'(x), 32'd10);
    chk("stall_y", 32'(y), 32'd5);
    chk("stall_line_len", 32'(line_len), HT);
    chk("stall_pulses", 32'(pulses), 32'd0);
    chk("stall_locked", 32'(locked), 32'd1);
    run_to(8, 0, 0);
    chk("locked_after_stall", 32'(locked), 32'd1);

    // Reset in the middle of the active area.
    run_to(8, 5, 5);
    chk("pre_reset_active", 32'(active), 32'd1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_red_o", 32'(red_o), 32'd0);
    chk("mid_rst_green_o", 32'(green_o), 32'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_line_len", 32'(line_len), 32'd0);
    repeat (5) @(posedge clock);
    #1;
    chk("mid_rst_hold_locked", 32'(locked), 32'd0);
    chk("mid_rst_hold_x", 32'(x), 32'd0);
    reset_n    = 1'b1;
    exp_locked = 1'b0;
    chk_xy     = 1'b0;

    // Fresh SEARCH -> ACQUIRE -> LOCKED after reset.
    run_to(8, VSS, 0);
    step();
    chk_xy = 1'b1;
    chk("post_rst_acquire", 32'(locked), 32'd0);
    run_to(9, VSS, 0);
    chk("post_rst_pending", 32'(locked), 32'd0);
    step();
    chk("post_rst_relock", 32'(locked), 32'd1);
    exp_locked = 1'b1;
    fs_cnt = 0;
    run_to(10, 0, 1);
    chk("post_rst_frame_start", fs_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
